// File: rtl/status_pkg.sv
// Shared types and constants for the status writer: FSM state encoding,
// word width and the position of the finish flag inside a status word.
package status_pkg;

   localparam int WORD_W     = 32;
   localparam int GAP_W      = 8;
   localparam int FINISH_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EMIT     = 2'd1,
      ST_WAIT     = 2'd2,
      ST_FINISHED = 2'd3
   } state_e;

   function automatic logic is_finish(input logic [WORD_W-1:0] word);
      return word[FINISH_BIT];
   endfunction

endpackage

// File: rtl/status_fifo.sv
// DEPTH x 32 circular buffer for status words. The caller never pushes
// when full or pops when empty; pointers wrap naturally at DEPTH (power of two).
module status_fifo
   import status_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    push,
   input  logic [WORD_W-1:0]       push_data,
   input  logic                    pop,
   output logic [WORD_W-1:0]       head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty,
   output logic                    full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [WORD_W-1:0] mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/status_writer.sv
// Buffers status words and emits them one at a time with an optional idle gap;
// a word with the finish bit set ends emission and latches an exit code.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_IDLE     | buffer empty, waiting for a word
//   ST_EMIT     | pop head, pulse out_valid for one cycle
//   ST_WAIT     | gap down-counter running between emissions
//   ST_FINISHED | finish word emitted; no accepts, no emissions until reset
module status_writer
   import status_pkg::*;
#(
   parameter string FORMAT = "status=%d",
   parameter int    DEPTH  = 4,
   parameter int    GAP    = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic              exit_valid,
   output logic [WORD_W-2:0] exit_code
);

   localparam int              CW    = $clog2(DEPTH) + 1;
   localparam logic [GAP_W-1:0] GAP_C = GAP_W'(GAP);

   state_e            state_q, state_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              alive_q;
   logic [WORD_W-1:0] last_q, last_d;
   logic              exit_valid_q, exit_valid_d;
   logic [WORD_W-2:0] exit_code_q, exit_code_d;

   logic              push;
   logic              pop;
   logic              more_after_pop;
   logic [WORD_W-1:0] fifo_head;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              fifo_full;

   status_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // alive_q keeps in_ready low during reset and for the first cycle after it.
   assign in_ready       = alive_q && !fifo_full && (state_q != ST_FINISHED);
   assign push           = in_valid && in_ready;
   assign pop            = (state_q == ST_EMIT);
   assign more_after_pop = (fifo_count > CW'(1)) || push;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         gap_q        <= '0;
         alive_q      <= 1'b0;
         last_q       <= '0;
         exit_valid_q <= 1'b0;
         exit_code_q  <= '0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         alive_q      <= 1'b1;
         last_q       <= last_d;
         exit_valid_q <= exit_valid_d;
         exit_code_q  <= exit_code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (is_finish(fifo_head)) begin
               state_d = ST_FINISHED;
            end else if (GAP > 0) begin
               state_d = ST_WAIT;
               gap_d   = GAP_C;
            end else if (more_after_pop) begin
               state_d = ST_EMIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // GAP cycles in WAIT: leave on the cycle the counter reaches zero.
            gap_d = gap_q - GAP_W'(1);
            if (gap_d == '0) begin
               state_d = fifo_empty ? ST_IDLE : ST_EMIT;
            end
         end
         ST_FINISHED: begin
            state_d = ST_FINISHED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      out_valid    = pop;
      out_data     = pop ? fifo_head : last_q;
      last_d       = out_data;
      exit_valid_d = exit_valid_q;
      exit_code_d  = exit_code_q;
      if (pop && is_finish(fifo_head)) begin
         exit_valid_d = 1'b1;
         exit_code_d  = fifo_head[WORD_W-1:1];
      end
   end

   assign exit_valid = exit_valid_q;
   assign exit_code  = exit_code_q;

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset_n && out_valid) begin
         $display("%s", $sformatf(FORMAT, out_data));
      end
   end
`endif

endmodule

// File: tb/tb_status_writer.sv
// Directed bench for status_writer: a per-cycle vector table for the GAP=0
// instance plus hand sequences for gap spacing, backpressure and mid-run reset.
module tb_status_writer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;

   logic        v0, rdy0, ov0, ex0;
   logic [31:0] d0, od0;
   logic [30:0] ec0;
   logic        v3, rdy3, ov3, ex3;
   logic [31:0] d3, od3;
   logic [30:0] ec3;
   logic        v10, rdy10, ov10, ex10;
   logic [31:0] d10, od10;
   logic [30:0] ec10;

   status_writer #(.FORMAT("status=%0d"), .DEPTH(4), .GAP(0)) dut_g0 (
      .clock(clock), .reset_n(reset_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
      .out_valid(ov0), .out_data(od0), .exit_valid(ex0), .exit_code(ec0));

   status_writer #(.FORMAT("g3 status=%0d"), .DEPTH(4), .GAP(3)) dut_g3 (
      .clock(clock), .reset_n(reset_n), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
      .out_valid(ov3), .out_data(od3), .exit_valid(ex3), .exit_code(ec3));

   status_writer #(.FORMAT("g10 status=%0d"), .DEPTH(4), .GAP(10)) dut_g10 (
      .clock(clock), .reset_n(reset_n), .in_valid(v10), .in_ready(rdy10), .in_data(d10),
      .out_valid(ov10), .out_data(od10), .exit_valid(ex10), .exit_code(ec10));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        vld;
      logic [31:0] data;
      logic        rdy;
      logic        ov;
      logic [31:0] od;
      logic        ex;
      logic [30:0] ec;
   } vec_t;

   function automatic vec_t mk(logic vld, logic [31:0] data, logic rdy, logic ov,
                               logic [31:0] od, logic ex, logic [30:0] ec);
      vec_t v;
      v.vld = vld; v.data = data; v.rdy = rdy; v.ov = ov; v.od = od; v.ex = ex; v.ec = ec;
      return v;
   endfunction

   vec_t tbl[16];

   int          pulse_t[$];
   logic [31:0] pulse_d[$];
   logic [31:0] sent[$];
   logic [31:0] got[$];
   int          occ;
   int          k;
   bit          saw_full;
   bit          pend;
   bit          drv;
   bit          psh;
   bit          seen;

   initial begin
      // inputs this cycle | expected outputs this cycle (before the edge)
      tbl[0]  = mk(1, 32'h10, 1, 0, 32'h00, 0, 0);
      tbl[1]  = mk(1, 32'h20, 1, 0, 32'h00, 0, 0);
      tbl[2]  = mk(1, 32'h30, 1, 1, 32'h10, 0, 0);
      tbl[3]  = mk(0, 32'h00, 1, 1, 32'h20, 0, 0);
      tbl[4]  = mk(0, 32'h00, 1, 1, 32'h30, 0, 0);
      tbl[5]  = mk(0, 32'h00, 1, 0, 32'h30, 0, 0);
      tbl[6]  = mk(0, 32'h00, 1, 0, 32'h30, 0, 0);
      tbl[7]  = mk(1, 32'h08, 1, 0, 32'h30, 0, 0);
      tbl[8]  = mk(1, 32'h07, 1, 0, 32'h30, 0, 0);
      tbl[9]  = mk(1, 32'h06, 1, 1, 32'h08, 0, 0);
      tbl[10] = mk(0, 32'h00, 1, 1, 32'h07, 0, 0);
      tbl[11] = mk(1, 32'h99, 0, 0, 32'h07, 1, 3);
      tbl[12] = mk(1, 32'h99, 0, 0, 32'h07, 1, 3);
      tbl[13] = mk(0, 32'h00, 0, 0, 32'h07, 1, 3);
      tbl[14] = mk(0, 32'h00, 0, 0, 32'h07, 1, 3);
      tbl[15] = mk(0, 32'h00, 0, 0, 32'h07, 1, 3);

      reset_n = 1'b0;
      v0 = 0; d0 = 0; v3 = 0; d3 = 0; v10 = 0; d10 = 0;
      repeat (3) @(negedge clock);
      check("rst_in_ready",   rdy0, 0);
      check("rst_out_valid",  ov0,  0);
      check("rst_out_data",   od0,  0);
      check("rst_exit_valid", ex0,  0);
      check("rst_exit_code",  ec0,  0);
      check("rst_in_ready_g10", rdy10, 0);
      reset_n = 1'b1;
      #1 check("rdy_at_release", rdy0, 0);
      @(negedge clock);
      check("rdy_after_release", rdy0, 1);

      for (int i = 0; i < 16; i++) begin
         check($sformatf("tbl%0d_in_ready", i),   rdy0, tbl[i].rdy);
         check($sformatf("tbl%0d_out_valid", i),  ov0,  tbl[i].ov);
         check($sformatf("tbl%0d_out_data", i),   od0,  tbl[i].od);
         check($sformatf("tbl%0d_exit_valid", i), ex0,  tbl[i].ex);
         check($sformatf("tbl%0d_exit_code", i),  ec0,  32'(tbl[i].ec));
         v0 = tbl[i].vld;
         d0 = tbl[i].data;
         @(negedge clock);
      end
      v0 = 0;

      // GAP=3: back-to-back pushes, pulses expected at t=2 and t=6
      for (int t = 0; t < 30; t++) begin
         if (ov3) begin
            pulse_t.push_back(t);
            pulse_d.push_back(od3);
         end
         v3 = (t < 2);
         d3 = (t == 0) ? 32'h2 : 32'h4;
         @(negedge clock);
      end
      v3 = 0;
      check("g3_pulse_count", pulse_t.size(), 2);
      if (pulse_t.size() == 2) begin
         check("g3_first_latency", pulse_t[0], 2);
         check("g3_pulse_spacing", pulse_t[1] - pulse_t[0], 4);
         check("g3_data0", pulse_d[0], 32'h2);
         check("g3_data1", pulse_d[1], 32'h4);
      end
      check("g3_not_finished", rdy3, 1);

      // GAP=10 backpressure: continuous offers, occupancy model predicts in_ready
      occ = 0; k = 0; saw_full = 0; pend = 0;
      for (int t = 0; t < 300; t++) begin
         drv = (t < 40);
         check("g10_in_ready", rdy10, (occ < 4) ? 1 : 0);
         if (pend) check("g10_rdy_after_pop", rdy10, 1);
         pend = 0;
         if (ov10) begin
            got.push_back(od10);
            if (!rdy10) pend = 1;
         end
         if (!rdy10) saw_full = 1;
         psh = drv && rdy10;
         d10 = 32'h100 + 32'(2 * k);
         if (psh) begin
            sent.push_back(d10);
            k++;
         end
         v10 = drv;
         occ = occ + (psh ? 1 : 0) - (ov10 ? 1 : 0);
         @(negedge clock);
         if (t >= 40 && occ == 0) break;
      end
      v10 = 0;
      check("g10_drained", occ, 0);
      check("g10_saw_full", saw_full, 1);
      check("g10_word_count", got.size(), sent.size());
      for (int i = 0; i < sent.size() && i < got.size(); i++)
         check($sformatf("g10_order%0d", i), got[i], sent[i]);
      check("g10_no_exit", ex10, 0);

      // Reset in the middle of WAIT with three words still buffered
      for (int t = 0; t < 4; t++) begin
         v3 = 1;
         d3 = 32'h10 + 32'(2 * t);
         @(negedge clock);
      end
      v3 = 0;
      check("g3_wait_no_pulse", ov3, 0);
      check("g3_wait_held_data", od3, 32'h10);
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", ov3,  0);
      check("midrst_out_data",  od3,  0);
      check("midrst_in_ready",  rdy3, 0);
      check("midrst_exit_g0",   ex0,  0);
      check("midrst_code_g0",   ec0,  0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      seen = 0;
      for (int t = 0; t < 5 && !seen; t++) begin
         @(negedge clock);
         seen = rdy3;
      end
      check("postrst_in_ready", seen, 1);
      check("postrst_g0_ready", rdy0, 1);
      pulse_d.delete();
      for (int t = 0; t < 20; t++) begin
         if (ov3) pulse_d.push_back(od3);
         v3 = (t == 0);
         d3 = 32'h40;
         @(negedge clock);
      end
      v3 = 0;
      check("postrst_pulse_count", pulse_d.size(), 1);
      if (pulse_d.size() > 0) check("postrst_data", pulse_d[0], 32'h40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
